cardinal_nic: RTL and testbench
===============================

CARDINAL_NIC -- requirements
Module: cardinal_nic

Interface
REQ-001 Parameter: DATA_W, default 64, flit width in bits.
REQ-002 Parameter: ADDR_W, default 2, processor register address width.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 addr  input  ADDR_W  processor register select.
REQ-006 d_in  input  DATA_W  processor write data.
REQ-007 d_out  output  DATA_W  processor read data, registered.
REQ-008 nicEn  input  1  processor access enable.
REQ-009 nicWrEn  input  1  1 = write, 0 = read; qualified by nicEn.
REQ-010 net_si  output  1  send strobe to router PE input port.
REQ-011 net_ri  input  1  router PE input port ready.
REQ-012 net_do  output  DATA_W  flit to router PE input port.
REQ-013 net_so  input  1  router PE output port send strobe.
REQ-014 net_ro  output  1  NIC ready to accept a flit from the router.
REQ-015 net_di  input  DATA_W  flit from router PE output port.
REQ-016 net_polarity  input  1  router external phase; selects the VC currently accepted.

Function
REQ-017 Register map: 0 = input buffer (RO), 1 = input status (RO), 2 = output buffer (WO), 3 = output status (RO).
REQ-018 Status register read data: {DATA_W-1 zeros, full flag}.
REQ-019 Input buffer: single DATA_W entry plus ib_full flag.
REQ-020 net_ro SHALL equal ~ib_full combinationally.
REQ-021 On a posedge with net_so=1 and ib_full=0: capture net_di into the input buffer and set ib_full.
REQ-022 On a posedge with net_so=1 and ib_full=1: ignore the flit; buffer contents and ib_full unchanged.
REQ-023 Read (nicEn=1, nicWrEn=0) of addr 0: d_out <= input buffer at that posedge; ib_full cleared at the same edge; data valid the cycle after the request (1-cycle latency).
REQ-024 Read of addr 0 while ib_full=0: d_out <= stale buffer contents; ib_full remains 0.
REQ-025 Read of addr 0 and net_so=1 in the same cycle: net_so is not qualified (net_ro=0 that cycle), so the flit is dropped; only the read takes effect.
REQ-026 Output buffer: single DATA_W entry plus ob_full flag.
REQ-027 Write (nicEn=1, nicWrEn=1) of addr 2 with ob_full=0: load d_in and set ob_full at that posedge.
REQ-028 Write of addr 2 with ob_full=1: ignored; the buffer is not overwritten.
REQ-029 net_do SHALL always drive the output buffer contents.
REQ-030 net_si SHALL equal ob_full & net_ri & (obuf[DATA_W-1] == net_polarity) combinationally.
REQ-031 On a posedge with net_si=1: clear ob_full; a write to addr 2 in that same cycle is ignored, because ob_full was 1 at the start of the cycle.
REQ-032 ob_full=1 with a VC/polarity mismatch: hold the flit and keep net_si=0 until polarity matches and net_ri=1; no timeout.
REQ-033 Writes to addr 0, 1 and 3 are ignored.
REQ-034 Reads of addr 2 return zero.
REQ-035 nicEn=0: no state change; d_out holds its value.
REQ-036 Read of addr 1: d_out <= {0, ib_full}. Read of addr 3: d_out <= {0, ob_full}. Both sample flags before any same-edge update.

Reset
REQ-037 While reset=0: ib_full=0, ob_full=0, both buffers=0, d_out=0, net_si=0, net_ro=1.
REQ-038 Reset asserted mid-operation discards buffered flits immediately (asynchronously); no partial send follows deassertion.
REQ-039 First state updates occur on the first posedge after reset returns to 1.

Verification
REQ-040 Scenario 1 -- Write addr 2 = 0x0000_0000_DEAD_BEEF (VC=0) with net_ri=1, net_polarity=0 -> net_si=1 one cycle after the write edge, with net_do=0x...DEADBEEF; addr 3 reads 0 afterwards.
REQ-041 Scenario 2 -- Write a flit with VC=1 while net_polarity=0 for 3 cycles, then 1 -> net_si stays 0 for 3 cycles, then pulses for exactly 1 cycle; a second write during the hold is ignored and net_do is unchanged.
REQ-042 Scenario 3 -- net_so=1 with net_di=0x8000_0000_1234_5678 -> net_ro=0 next cycle and addr 1 reads 1; read addr 0 -> d_out=0x8000_0000_1234_5678 one cycle later and net_ro=1 again.
REQ-043 Scenario 4 -- Two consecutive net_so pulses carrying A then B, with no read between -> addr 0 reads A and B is dropped.
REQ-044 Scenario 5 -- Read addr 0 and net_so=1 in the same cycle while full -> d_out = old flit, ib_full=0, new flit not captured.
REQ-045 Scenario 6 -- Fill both buffers, pulse reset low for 3 ns between edges -> all flags 0, net_ro=1, net_si=0, d_out=0 immediately.

Source files
------------

// File: rtl/cardinal_nic.sv
// Network interface between a processor register port and a router PE port.
// It holds one inbound flit and one outbound flit, and each buffer has its own full flag.
module cardinal_nic #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  input  logic              nicEn,
  input  logic              nicWrEn,
  output logic              net_si,
  input  logic              net_ri,
  output logic [DATA_W-1:0] net_do,
  input  logic              net_so,
  output logic              net_ro,
  input  logic [DATA_W-1:0] net_di,
  input  logic              net_polarity
);

  localparam logic [ADDR_W-1:0] ADDR_IBUF    = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_ISTATUS = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_OBUF    = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] ADDR_OSTATUS = ADDR_W'(3);

  logic [DATA_W-1:0] ibuf_q, ibuf_d;
  logic              ib_full_q, ib_full_d;
  logic [DATA_W-1:0] obuf_q, obuf_d;
  logic              ob_full_q, ob_full_d;
  logic [DATA_W-1:0] d_out_q, d_out_d;

  logic rd_en;
  logic wr_en;
  logic send;

  assign rd_en  = nicEn & ~nicWrEn;
  assign wr_en  = nicEn & nicWrEn;

  // The MSB of the flit selects its virtual channel. The router accepts only the VC that matches its current phase.
  assign send   = ob_full_q & net_ri & (obuf_q[DATA_W-1] == net_polarity);

  assign net_si = send;
  assign net_ro = ~ib_full_q;
  assign net_do = obuf_q;
  assign d_out  = d_out_q;

  always_comb begin
    ibuf_d    = ibuf_q;
    ib_full_d = ib_full_q;
    if (rd_en && addr == ADDR_IBUF) begin
      ib_full_d = 1'b0;
    end
    // A flit is taken only when the buffer was empty at the start of the cycle.
    // If the buffer is full, the flit is dropped, even when a read empties the buffer in the same cycle.
    if (net_so && !ib_full_q) begin
      ibuf_d    = net_di;
      ib_full_d = 1'b1;
    end
  end

  always_comb begin
    obuf_d    = obuf_q;
    ob_full_d = ob_full_q;
    if (send) begin
      ob_full_d = 1'b0;
    end
    if (wr_en && addr == ADDR_OBUF && !ob_full_q) begin
      obuf_d    = d_in;
      ob_full_d = 1'b1;
    end
  end

  always_comb begin
    d_out_d = d_out_q;
    if (rd_en) begin
      case (addr)
        ADDR_IBUF:    d_out_d = ibuf_q;
        ADDR_ISTATUS: d_out_d = {{(DATA_W-1){1'b0}}, ib_full_q};
        ADDR_OSTATUS: d_out_d = {{(DATA_W-1){1'b0}}, ob_full_q};
        default:      d_out_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ibuf_q    <= '0;
      ib_full_q <= 1'b0;
      obuf_q    <= '0;
      ob_full_q <= 1'b0;
      d_out_q   <= '0;
    end else begin
      ibuf_q    <= ibuf_d;
      ib_full_q <= ib_full_d;
      obuf_q    <= obuf_d;
      ob_full_q <= ob_full_d;
      d_out_q   <= d_out_d;
    end
  end

endmodule

// File: tb/tb_cardinal_nic.sv
// Scoreboard bench for cardinal_nic. Register reads and sent flits are checked against expected values held in queues.
module tb_cardinal_nic;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  addr = '0;
  logic [63:0] d_in = '0;
  logic [63:0] d_out;
  logic        nicEn = 1'b0;
  logic        nicWrEn = 1'b0;
  logic        net_si;
  logic        net_ri = 1'b0;
  logic [63:0] net_do;
  logic        net_so = 1'b0;
  logic        net_ro;
  logic [63:0] net_di = '0;
  logic        net_polarity = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  logic [63:0] rd_q[$];
  logic [63:0] tx_q[$];

  cardinal_nic #(.DATA_W(64), .ADDR_W(2)) dut (
    .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
    .nicEn(nicEn), .nicWrEn(nicWrEn), .net_si(net_si), .net_ri(net_ri),
    .net_do(net_do), .net_so(net_so), .net_ro(net_ro), .net_di(net_di),
    .net_polarity(net_polarity)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    else begin
      n_pass++;
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [1:0] a, input logic [63:0] exp);
    addr = a; nicEn = 1'b1; nicWrEn = 1'b0;
    rd_q.push_back(exp);
    tick();
    nicEn = 1'b0;
    check($sformatf("read_addr%0d", a), d_out, rd_q.pop_front());
  endtask

  task automatic do_write(input logic [1:0] a, input logic [63:0] data, input bit accept);
    addr = a; d_in = data; nicEn = 1'b1; nicWrEn = 1'b1;
    if (accept) tx_q.push_back(data);
    tick();
    nicEn = 1'b0; nicWrEn = 1'b0;
  endtask

  task automatic net_send(input logic [63:0] data);
    net_so = 1'b1; net_di = data;
    tick();
    net_so = 1'b0;
  endtask

  task automatic check_send(input logic exp_si);
    check("net_si", net_si, exp_si);
    if (net_si) begin
      check("tx_pending", tx_q.size(), 64'd1);
      if (tx_q.size() > 0) check("net_do", net_do, tx_q.pop_front());
    end
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_net_ro", net_ro, 1);
    check("rst_net_si", net_si, 0);
    check("rst_d_out", d_out, 0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Scenario 1: a VC0 flit is sent immediately
    net_ri = 1'b1; net_polarity = 1'b0;
    do_write(2'd2, 64'h0000_0000_DEAD_BEEF, 1);
    check_send(1);
    tick();
    check_send(0);
    do_read(2'd3, 64'd0);

    // Scenario 2: a VC1 flit is held until the polarity matches
    do_write(2'd2, 64'h8000_0000_0000_00A1, 1);
    check_send(0);
    do_write(2'd2, 64'h0000_0000_0000_0BAD, 0);
    check_send(0);
    tick();
    check_send(0);
    check("hold_net_do", net_do, 64'h8000_0000_0000_00A1);
    net_polarity = 1'b1;
    #1;
    check_send(1);
    tick();
    check_send(0);
    do_read(2'd3, 64'd0);

    // The send is held while the router is not ready
    net_ri = 1'b0; net_polarity = 1'b0;
    do_write(2'd2, 64'h0000_0000_0000_0C0C, 1);
    check_send(0);
    do_read(2'd3, 64'd1);
    net_ri = 1'b1;
    #1;
    check_send(1);
    tick();
    check_send(0);

    // Scenario 3: receive a flit and read it back
    net_send(64'h8000_0000_1234_5678);
    check("s3_net_ro_full", net_ro, 0);
    do_read(2'd1, 64'd1);
    do_read(2'd0, 64'h8000_0000_1234_5678);
    check("s3_net_ro_empty", net_ro, 1);
    tick(); tick();
    check("dout_hold", d_out, 64'h8000_0000_1234_5678);

    // Writes to addresses other than 2 are ignored, and a read of addr 2 returns zero
    do_write(2'd0, 64'h5555_5555_5555_5555, 0);
    do_write(2'd3, 64'h5555_5555_5555_5555, 0);
    do_read(2'd1, 64'd0);
    do_read(2'd3, 64'd0);
    do_read(2'd2, 64'd0);
    check_send(0);

    // Scenario 4: the second flit is dropped while the buffer is full
    net_send(64'h0000_0000_0000_AAAA);
    net_send(64'h0000_0000_0000_BBBB);
    do_read(2'd0, 64'h0000_0000_0000_AAAA);
    do_read(2'd1, 64'd0);

    // Scenario 5: a read and an incoming flit in the same cycle while the buffer is full
    net_send(64'h0000_0000_0000_1111);
    net_so = 1'b1; net_di = 64'h0000_0000_0000_2222;
    do_read(2'd0, 64'h0000_0000_0000_1111);
    net_so = 1'b0;
    check("s5_net_ro", net_ro, 1);
    do_read(2'd1, 64'd0);
    do_read(2'd0, 64'h0000_0000_0000_1111);

    // Scenario 6: reset pulse while both buffers are full
    net_ri = 1'b0; net_polarity = 1'b0;
    do_write(2'd2, 64'h0000_0000_0000_0F0F, 1);
    net_send(64'h0000_0000_0000_3333);
    do_read(2'd1, 64'd1);
    net_ri = 1'b1;
    #1;
    check_send(1);
    tx_q.delete();
    #1;
    reset = 1'b0;
    #1;
    check("s6_net_ro", net_ro, 1);
    check("s6_net_si", net_si, 0);
    check("s6_d_out", d_out, 0);
    check("s6_net_do", net_do, 0);
    #2;
    reset = 1'b1;
    tick();
    check_send(0);
    do_read(2'd1, 64'd0);
    do_read(2'd3, 64'd0);
    do_read(2'd0, 64'd0);

    check("rd_q_empty", rd_q.size(), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
